// File: rtl/hub_pkg.sv
`default_nettype none
// ============================================================================
// hub_pkg : shared types and helpers for the hub TX link router
// Rev 1.0
// ============================================================================
package hub_pkg;

  typedef enum logic [0:0] {
    PORT_IDLE = 1'b0,
    PORT_SEND = 1'b1
  } port_state_e;

  localparam int MAX_ID_WIDTH  = 32;
  localparam int MAX_MSG_WIDTH = 256;

  function automatic int calc_beats(input int w, input int p);
    return ((w / p) < 1) ? 1 : (w / p);
  endfunction

  function automatic int calc_cnt_width(input int beats);
    return (beats <= 2) ? 1 : $clog2(beats);
  endfunction

  function automatic int id_lsb(input int w, input int fw);
    return w - fw;
  endfunction

  function automatic logic [MAX_ID_WIDTH-1:0] id_mask(input int fw);
    logic [MAX_ID_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_ID_WIDTH; i++) begin
      if (i < fw) m[i] = 1'b1;
    end
    return m;
  endfunction

  // All-ones ID is the broadcast destination
  function automatic logic [MAX_ID_WIDTH-1:0] bcast_id(input int fw);
    return id_mask(fw);
  endfunction

  function automatic logic [MAX_ID_WIDTH-1:0] dest_id(input logic [MAX_MSG_WIDTH-1:0] msg,
                                                      input int w, input int fw);
    logic [MAX_MSG_WIDTH-1:0] sh;
    sh = msg >> id_lsb(w, fw);
    return MAX_ID_WIDTH'(sh) & id_mask(fw);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hub_rr_arbiter.sv
`default_nettype none
// ============================================================================
// hub_rr_arbiter : round-robin one-hot grant, pointer advances past winner on accept
// Rev 1.0
// ============================================================================
module hub_rr_arbiter #(
  parameter int SRC_COUNT = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [SRC_COUNT-1:0] req_i,
  input  logic                 accept_i,
  output logic [SRC_COUNT-1:0] grant_o
);
  localparam int PTR_W = (SRC_COUNT <= 1) ? 1 : $clog2(SRC_COUNT);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < SRC_COUNT; i++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(SRC_COUNT)) sum = sum - (PTR_W+1)'(SRC_COUNT);
      idx = PTR_W'(sum);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        if (accept_i) ptr_d = (idx == PTR_W'(SRC_COUNT-1)) ? '0 : idx + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/hub_tx_link_router.sv
`default_nettype none
// ============================================================================
// hub_tx_link_router : routes wide source messages by FPGA ID to per-port serializers.
// Optional broadcast to all neighbour ports with HUB_TX_BCAST_EN.      Rev 1.0
// ============================================================================
module hub_tx_link_router
  import hub_pkg::*;
#(
  parameter int HUB_FIFO_WIDTH          = 32,
  parameter int HUB_FIFO_PHYSICAL_WIDTH = 8,
  parameter int FPGAID_WIDTH            = 4,
  parameter int SRC_COUNT               = 9,
  parameter int FPGA_NEIGHBORS          = 2
) (
  input  logic                                           clk,
  input  logic                                           reset_n,
  input  logic [HUB_FIFO_WIDTH*SRC_COUNT-1:0]            src_data,
  input  logic [SRC_COUNT-1:0]                           src_valid,
  output logic [SRC_COUNT-1:0]                           src_ready,
  input  logic [FPGAID_WIDTH*FPGA_NEIGHBORS-1:0]         neighbor_id,
  output logic [HUB_FIFO_PHYSICAL_WIDTH*(FPGA_NEIGHBORS+1)-1:0] link_data,
  output logic [FPGA_NEIGHBORS:0]                        link_valid,
  input  logic [FPGA_NEIGHBORS:0]                        link_ready,
  output logic                                           busy
);
  localparam int W      = HUB_FIFO_WIDTH;
  localparam int P      = HUB_FIFO_PHYSICAL_WIDTH;
  localparam int FID    = FPGAID_WIDTH;
  localparam int S      = SRC_COUNT;
  localparam int N      = FPGA_NEIGHBORS;
  localparam int NP     = N + 1;
  localparam int BEATS  = calc_beats(W, P);
  localparam int CNT_W  = calc_cnt_width(BEATS);
  localparam int PORT_W = (NP <= 1) ? 1 : $clog2(NP);

  logic [FID-1:0]    w_dest  [S];
  logic [PORT_W-1:0] w_route [S];
  logic [S-1:0]      w_req   [NP];
  logic [S-1:0]      w_take  [NP];
  logic [S-1:0]      w_bcast_req, w_bcast_grant;
  logic              w_bcast_fire;
  logic [NP-1:0]     w_load_ok, w_send;
  logic              busy_q;

  // Descending scan so the lowest matching neighbour index wins
  always_comb begin
    for (int s = 0; s < S; s++) begin
      w_dest[s]  = FID'(dest_id(MAX_MSG_WIDTH'(src_data[s*W +: W]), W, FID));
      w_route[s] = '0;
      for (int i = N; i >= 1; i--) begin
        if (w_dest[s] == neighbor_id[(i-1)*FID +: FID]) w_route[s] = PORT_W'(i);
      end
    end
  end

`ifdef HUB_TX_BCAST_EN
  always_comb begin
    for (int s = 0; s < S; s++) begin
      w_bcast_req[s] = src_valid[s] && (w_dest[s] == FID'(bcast_id(FID)));
    end
  end
  assign w_bcast_grant = w_bcast_req & (~w_bcast_req + S'(1));
  assign w_bcast_fire  = (&w_load_ok[NP-1:1]) && (|w_bcast_req);
`else
  assign w_bcast_req   = '0;
  assign w_bcast_grant = '0;
  assign w_bcast_fire  = 1'b0;
`endif

  always_comb begin
    w_req = '{default: '0};
    for (int p = 0; p < NP; p++) begin
      for (int s = 0; s < S; s++) begin
        w_req[p][s] = src_valid[s] && !w_bcast_req[s] && (w_route[s] == PORT_W'(p));
      end
    end
  end

  for (genvar p = 0; p < NP; p++) begin : g_port
    port_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     shreg_q, shreg_d, msg;
    logic [S-1:0]     grant, sel;
    logic             hs, last, accept, load_bc, load;

    assign hs           = (state_q == PORT_SEND) && link_ready[p];
    assign last         = (cnt_q == CNT_W'(BEATS-1));
    assign w_load_ok[p] = (state_q == PORT_IDLE) || (hs && last);
    assign load_bc      = (p != 0) && w_bcast_fire;
    assign accept       = w_load_ok[p] && !load_bc;

    hub_rr_arbiter #(.SRC_COUNT(S)) u_arb (
      .clk_i    (clk),
      .rst_ni   (reset_n),
      .req_i    (w_req[p]),
      .accept_i (accept),
      .grant_o  (grant)
    );

    assign w_take[p] = accept ? grant : '0;
    assign sel       = load_bc ? w_bcast_grant : w_take[p];
    assign load      = |sel;

    always_comb begin
      msg = '0;
      for (int s = 0; s < S; s++) begin
        if (sel[s]) msg = msg | src_data[s*W +: W];
      end
    end

    // A load on the last-beat handshake overrides the return to IDLE
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      if (hs) begin
        shreg_d = shreg_q << P;
        cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
        if (last) state_d = PORT_IDLE;
      end
      if (load) begin
        state_d = PORT_SEND;
        cnt_d   = '0;
        shreg_d = msg;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= PORT_IDLE;
        cnt_q   <= '0;
        shreg_q <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        shreg_q <= shreg_d;
      end
    end

    assign w_send[p]             = (state_q == PORT_SEND);
    assign link_valid[p]         = w_send[p];
    assign link_data[p*P +: P]   = shreg_q[W-1 -: P];
  end

  always_comb begin
    src_ready = w_bcast_fire ? w_bcast_grant : '0;
    for (int p = 0; p < NP; p++) src_ready = src_ready | w_take[p];
    if (!reset_n) src_ready = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_q <= 1'b0;
    else          busy_q <= (|src_valid) || (|w_send);
  end

  assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_hub_tx_link_router.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_hub_tx_link_router : directed checks of routing, round robin, stall and reset
// Rev 1.0
// ============================================================================
module tb_hub_tx_link_router;
  localparam int W = 32, P = 8, N = 2, S = 9, FID = 4, NP = 3;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [W*S-1:0]     src_data;
  logic [S-1:0]       src_valid, src_ready;
  logic [FID*N-1:0]   neighbor_id;
  logic [P*NP-1:0]    link_data;
  logic [NP-1:0]      link_valid, link_ready;
  logic               busy;

  always #5 clk = ~clk;

  hub_tx_link_router #(
    .HUB_FIFO_WIDTH(W), .HUB_FIFO_PHYSICAL_WIDTH(P), .FPGAID_WIDTH(FID),
    .SRC_COUNT(S), .FPGA_NEIGHBORS(N)
  ) dut (
    .clk(clk), .reset_n(reset_n), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .neighbor_id(neighbor_id), .link_data(link_data),
    .link_valid(link_valid), .link_ready(link_ready), .busy(busy)
  );

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  logic [31:0] q_msg [S][4];
  int          q_n [S];
  int          q_i [S];
  int          rdy_cnt [S];
  logic [7:0]  blog [NP][64];
  int          hs_cnt [NP];
  int          first_cyc [NP];
  int          last_cyc [NP];
  int          cyc, held, stall_left;
  logic [7:0]  stall_byte;
  logic [S-1:0] rdy_s;

  task automatic apply_src();
    for (int s = 0; s < S; s++) begin
      src_valid[s] = (q_i[s] < q_n[s]);
      if (q_i[s] < q_n[s]) src_data[s*W +: W] = q_msg[s][q_i[s]];
      else                 src_data[s*W +: W] = '0;
    end
  endtask

  task automatic clear_mon();
    for (int s = 0; s < S; s++) begin q_n[s] = 0; q_i[s] = 0; rdy_cnt[s] = 0; end
    for (int p = 0; p < NP; p++) begin hs_cnt[p] = 0; first_cyc[p] = -1; last_cyc[p] = -1; end
    cyc = 0; held = 0; stall_left = 0; stall_byte = 8'h00;
  endtask

  // One clock: decide port-1 stall, sample at negedge, advance sources after posedge
  task automatic cycle();
    @(negedge clk);
    link_ready[1] = !(stall_left > 0 && link_valid[1] && link_data[15:8] == stall_byte);
    if (!link_ready[1]) stall_left--;
    #1;
    if (link_valid[1] && link_data[15:8] == stall_byte) held++;
    rdy_s = src_ready;
    for (int s = 0; s < S; s++) if (rdy_s[s]) rdy_cnt[s]++;
    for (int p = 0; p < NP; p++) begin
      if (link_valid[p] && link_ready[p]) begin
        if (hs_cnt[p] == 0) first_cyc[p] = cyc;
        last_cyc[p] = cyc;
        if (hs_cnt[p] < 64) blog[p][hs_cnt[p]] = link_data[p*P +: P];
        hs_cnt[p]++;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    for (int s = 0; s < S; s++) if (rdy_s[s]) q_i[s]++;
    apply_src();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  function automatic logic [31:0] msg_of(input int p, input int k);
    return {blog[p][4*k], blog[p][4*k+1], blog[p][4*k+2], blog[p][4*k+3]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    neighbor_id = {4'd3, 4'd1};
    link_ready  = '1;
    src_valid   = '0;
    src_data    = '0;
    clear_mon();
    q_n[0] = 1; q_msg[0][0] = 32'h1ABCDEF0;
    apply_src();
    #22;
    check("rst_src_ready", 32'(src_ready), 32'h0);
    check("rst_link_valid", 32'(link_valid), 32'h0);
    check("rst_link_data", 32'(link_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    clear_mon();
    apply_src();
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: single message to port 1
    clear_mon();
    q_n[0] = 1; q_msg[0][0] = 32'h1ABCDEF0;
    apply_src();
    cycle();
    check("t1_first_ready", 32'(rdy_s), 32'h001);
    run(8);
    check("t1_ready_pulses", 32'(rdy_cnt[0]), 32'd1);
    check("t1_port1_msg", msg_of(1, 0), 32'h1ABCDEF0);
    check("t1_port1_beats", 32'(hs_cnt[1]), 32'd4);
    check("t1_port1_span", 32'(last_cyc[1] - first_cyc[1]), 32'd3);
    check("t1_other_ports", 32'(hs_cnt[0] + hs_cnt[2]), 32'd0);
    check("t1_busy_idle", 32'(busy), 32'h0);

    // 2: two sources stream to port 2, round robin, zero bubble
    clear_mon();
    q_n[2] = 2; q_msg[2][0] = 32'h32A0B000; q_msg[2][1] = 32'h32A0B001;
    q_n[5] = 2; q_msg[5][0] = 32'h35A0B000; q_msg[5][1] = 32'h35A0B001;
    apply_src();
    cycle();
    check("t2_busy_active", 32'(busy), 32'h1);
    run(21);
    check("t2_beats", 32'(hs_cnt[2]), 32'd16);
    check("t2_span", 32'(last_cyc[2] - first_cyc[2]), 32'd15);
    check("t2_msg0", msg_of(2, 0), 32'h32A0B000);
    check("t2_msg1", msg_of(2, 1), 32'h35A0B000);
    check("t2_msg2", msg_of(2, 2), 32'h32A0B001);
    check("t2_msg3", msg_of(2, 3), 32'h35A0B001);

    // 3: port 1 stalled 3 cycles on beat 2, port 2 unaffected
    clear_mon();
    q_n[0] = 1; q_msg[0][0] = 32'h11223344;
    q_n[2] = 2; q_msg[2][0] = 32'h32A0B000; q_msg[2][1] = 32'h32A0B001;
    stall_byte = 8'h33; stall_left = 3;
    apply_src();
    run(16);
    check("t3_port1_msg", msg_of(1, 0), 32'h11223344);
    check("t3_port1_held", 32'(held), 32'd4);
    check("t3_port1_span", 32'(last_cyc[1] - first_cyc[1]), 32'd6);
    check("t3_port2_beats", 32'(hs_cnt[2]), 32'd8);
    check("t3_port2_span", 32'(last_cyc[2] - first_cyc[2]), 32'd7);

    // 4: unknown ID goes to port 0 only
    clear_mon();
    q_n[8] = 1; q_msg[8][0] = 32'h7EADBEEF;
    apply_src();
    run(10);
    check("t4_port0_msg", msg_of(0, 0), 32'h7EADBEEF);
    check("t4_port0_beats", 32'(hs_cnt[0]), 32'd4);
    check("t4_nb_ports", 32'(hs_cnt[1] + hs_cnt[2]), 32'd0);
    check("t4_busy_idle", 32'(busy), 32'h0);

    // 5: asynchronous reset while beat 2 is on port 1
    clear_mon();
    q_n[0] = 1; q_msg[0][0] = 32'h1ABCDEF0;
    stall_byte = 8'hDE; stall_left = 100;
    apply_src();
    for (int k = 0; k < 10 && held == 0; k++) cycle();
    check("t5_beat2_seen", 32'(held), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(link_valid), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_data", 32'(link_data), 32'h0);
    check("t5_rst_ready", 32'(src_ready), 32'h0);
    clear_mon();
    link_ready = '1;
    q_n[0] = 1; q_msg[0][0] = 32'h10000000;
    q_n[1] = 1; q_msg[1][0] = 32'h11111111;
    apply_src();
    #1;
    reset_n = 1'b1;
    #1;
    check("t5_first_grant", 32'(src_ready), 32'h001);
    run(14);
    check("t5_msg0", msg_of(1, 0), 32'h10000000);
    check("t5_msg1", msg_of(1, 1), 32'h11111111);

    // 6: all-ones destination
    clear_mon();
    q_n[4] = 1; q_msg[4][0] = 32'hF0000001;
    apply_src();
    run(10);
`ifdef HUB_TX_BCAST_EN
    check("t6_port1_msg", msg_of(1, 0), 32'hF0000001);
    check("t6_port2_msg", msg_of(2, 0), 32'hF0000001);
    check("t6_same_start", 32'(first_cyc[1] - first_cyc[2]), 32'd0);
    check("t6_port0_beats", 32'(hs_cnt[0]), 32'd0);
    check("t6_ready_pulses", 32'(rdy_cnt[4]), 32'd1);
`else
    check("t6_port0_msg", msg_of(0, 0), 32'hF0000001);
    check("t6_nb_ports", 32'(hs_cnt[1] + hs_cnt[2]), 32'd0);
    check("t6_ready_pulses", 32'(rdy_cnt[4]), 32'd1);
`endif
    check("end_busy", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
